elastic_pipe: RTL and testbench



---
 rtl/gcn_pipe_pkg.sv | 13 +
 rtl/elastic_stage.sv | 35 +++
 rtl/elastic_pipe.sv | 95 +++++++++
 tb/tb_elastic_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pipe_pkg.sv
// Shared constants and helpers for the GCN datapath pipeline blocks.
package gcn_pipe_pkg;

    // Default data width and stage count used between GCN datapath units.
    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One register stage of the elastic pipeline: a valid bit plus a data word.
// The stage is ready whenever it is empty or its downstream neighbour is ready,
// so an empty slot always absorbs the word above it and bubbles collapse.
module elastic_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    assign ready = !valid || dn_ready;

    // Valid/data register: flush clears only valid; data loads only on a real word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake on both
// sides, bubble collapsing, synchronous flush and a registered occupancy count.
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both high; valid never depends on ready, and a producer holds its
// valid and data stable until the transfer happens.
//
// in_ready is a combinational function of out_ready through the ready chain
// (one OR gate per stage). That path is intentional and must be constrained as
// a through-path during synthesis; the data path itself is fully registered.
module elastic_pipe
    import gcn_pipe_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    // Next-edge valid bit of each stage, used to keep count in step with v[].
    logic [DEPTH-1:0] v_next;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             dn_ready;
        logic             st_valid;
        logic [WIDTH-1:0] st_data;
        logic             st_ready;

        if (i == 0) begin : g_head
            assign up_valid = in_valid && !flush;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = g_stage[i-1].st_valid;
            assign up_data  = g_stage[i-1].st_data;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_mid
            assign dn_ready = g_stage[i+1].st_ready;
        end

        elastic_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_ready (dn_ready),
            .valid    (st_valid),
            .data     (st_data),
            .ready    (st_ready)
        );

        // Mirrors the stage's own valid update so count can be registered.
        assign v_next[i] = !flush && (st_ready ? up_valid : st_valid);
    end

    assign in_ready  = g_stage[0].st_ready && !flush;
    assign out_valid = g_stage[DEPTH-1].st_valid;
    assign out_data  = g_stage[DEPTH-1].st_data;

    // Popcount of the valid bits the stages will hold after the next edge.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + CNT_W'(v_next[i]);
        end
    end

    // Occupancy register, updated on the same edge as the stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed testbench for elastic_pipe (WIDTH=16, DEPTH=4).
module tb_elastic_pipe;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    elastic_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_in(input logic iv, input logic [WIDTH-1:0] id,
                          input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Settle at the falling edge and run the scoreboard on this cycle's handshakes.
    task automatic sample();
        logic [WIDTH-1:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_order", 32'(out_data), 32'(e));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_c;
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);

        // reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // stream 0x0001..0x0010 with out_ready held high
        for (int c = 0; c < 20; c++) begin
            if (c < 16) set_in(1'b1, WIDTH'(c + 1), 1'b1, 1'b0);
            else        set_in(1'b0, '0, 1'b1, 1'b0);
            sample();
            exp_c = ((c < 16) ? c : 16) - ((c > 4) ? c - 4 : 0);
            check("stream_count", 32'(count), 32'(exp_c));
            if (c >= 4) begin
                check("stream_out_valid", 32'(out_valid), 32'd1);
                check("stream_out_data", 32'(out_data), 32'(c - 3));
            end else begin
                check("stream_out_valid", 32'(out_valid), 32'd0);
            end
            tick();
        end

        // backpressure fill: 6 offered, 4 accepted
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, WIDTH'((c < 4) ? c + 1 : 5), 1'b0, 1'b0);
            sample();
            check("bp_in_ready", 32'(in_ready), (c < 4) ? 32'd1 : 32'd0);
            if (c >= 4) begin
                check("bp_count", 32'(count), 32'd4);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_data", 32'(out_data), 32'h0001);
            end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            sample();
            if (c < 4) check("bp_drain_data", 32'(out_data), 32'(c + 1));
            else       check("bp_drain_empty", 32'(out_valid), 32'd0);
            tick();
        end
        check("bp_count_end", 32'(count), 32'd0);

        // bubble collapse: words on cycles 0 and 3, out_ready low through cycle 6
        for (int c = 0; c < 9; c++) begin
            set_in((c == 0) || (c == 3), (c == 0) ? 16'h00A1 : 16'h00B2, (c >= 7), 1'b0);
            sample();
            if (c <= 6) check("bub_in_ready", 32'(in_ready), 32'd1);
            if (c == 6) begin
                check("bub_count", 32'(count), 32'd2);
                check("bub_out_data", 32'(out_data), 32'h00A1);
            end
            if (c == 7) check("bub_first", 32'(out_data), 32'h00A1);
            if (c == 8) begin
                check("bub_second_valid", 32'(out_valid), 32'd1);
                check("bub_second", 32'(out_data), 32'h00B2);
            end
            tick();
        end

        // simultaneous enqueue/dequeue while full
        for (int c = 0; c < 18; c++) begin
            if (c < 4)       set_in(1'b1, WIDTH'(16'h0201 + c), 1'b0, 1'b0);
            else if (c < 14) set_in(1'b1, WIDTH'(16'h0201 + c), 1'b1, 1'b0);
            else             set_in(1'b0, '0, 1'b1, 1'b0);
            sample();
            if (c >= 4 && c < 14) begin
                check("full_in_ready", 32'(in_ready), 32'd1);
                check("full_out_valid", 32'(out_valid), 32'd1);
                check("full_count", 32'(count), 32'd4);
                check("full_out_data", 32'(out_data), 32'(16'h0201 + c - 4));
            end
            tick();
        end
        check("full_drained", 32'(count), 32'd0);

        // flush with three words in flight and a word offered in the flush cycle
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, WIDTH'(16'h0301 + c), 1'b0, 1'b0);
            sample();
            tick();
        end
        set_in(1'b1, 16'h03FF, 1'b0, 1'b1);
        sample();
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_count_before", 32'(count), 32'd3);
        tick();
        exp_q.delete();
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            sample();
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_count", 32'(count), 32'd0);
            tick();
        end

        // asynchronous reset while full
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, WIDTH'(16'h0401 + c), 1'b0, 1'b0);
            sample();
            tick();
        end
        set_in(1'b0, '0, 1'b0, 1'b0);
        sample();
        check("ar_count_full", 32'(count), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_in((c == 0), 16'h0501, 1'b1, 1'b0);
            sample();
            if (c == 0) check("ar_in_ready", 32'(in_ready), 32'd1);
            if (c == 4) begin
                check("ar_new_valid", 32'(out_valid), 32'd1);
                check("ar_new_data", 32'(out_data), 32'h0501);
            end else begin
                check("ar_new_idle", 32'(out_valid), 32'd0);
            end
            tick();
        end
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
